roulette_spinner: RTL and testbench
===================================

// Module: roulette_spinner
// PURPOSE
//  Upstream number source for the roulette game FSM. On a player spin request it
//  "spins" for a fixed time, then presents a settled result in 1..31 on randnum
//  with rand_valid held high. The game consumes the result when the player presses startGame.
//  A fast-changing spin_display value drives the HEX digits while the wheel turns.
// PARAMETERS
//  SEED        5'b00001  LFSR reset value; 0 is illegal, and 0 is replaced by 5'b00001.
//  SPIN_CYCLES 32'd50_000_000  spin duration in Clock cycles, >=2 (1 s at 50 MHz).
//  TICK_DIV    32'd2_500_000   Clock cycles between spin_display updates, >=1.
// PORTS
//  Clock         in   1  system clock, all state on rising edge
//  reset         in   1  asynchronous, active-high reset
//  spin          in   1  spin request level (KEY/SW); only its rising edge acts
//  randnum       out  5  settled result, 1..31 whenever rand_valid=1
//  rand_valid    out  1  result ready and stable; low while spinning and after reset
//  busy          out  1  high for exactly SPIN_CYCLES cycles per spin
//  spin_display  out  5  value for HEX display: rolling while busy, equals randnum otherwise
// BEHAVIOUR
//  Reset (async, dominant over every other input, mid-spin included): state=IDLE,
//   lfsr=SEED, spin_q=0, randnum=0, rand_valid=0, busy=0, spin_display=0, cnt=0, tick=0.
//  LFSR: 5-bit Fibonacci, x^5+x^3+1, lfsr <= {lfsr[3:0], lfsr[4]^lfsr[2]}.
//   It advances every Clock cycle in every state, so press timing adds entropy.
//   Period 31, value never 0, so no range mapping is needed.
//  Edge detect: spin_q <= spin each cycle; spin_rise = spin & ~spin_q.
//  FSM states: IDLE, SPIN, DONE.
//   IDLE: spin_rise -> SPIN; cnt<=SPIN_CYCLES-1, tick<=TICK_DIV-1, busy<=1.
//   SPIN: cnt decrements each cycle. tick counts down; at tick==0, spin_display<=lfsr
//     and tick<=TICK_DIV-1. spin_rise is ignored (no restart, no extension).
//     cnt==0 -> DONE; randnum<=lfsr, spin_display<=lfsr, rand_valid<=1, busy<=0.
//   DONE: outputs hold. spin_rise -> SPIN with the same loads as IDLE, and rand_valid<=0
//     on that same edge (result withdrawn 1 cycle after the press edge).
//  Latency: spin_rise sampled at edge N -> busy=1 after edge N. After edge N+SPIN_CYCLES,
//   busy=0 and rand_valid=1.
//  Spin held high: a single spin only; the player must release and press again.
//  spin high when reset deasserts: spin_q=0, so a rise is seen on the first edge.
//   This is accepted behaviour.
//  Counters: 32-bit unsigned. No wrap is possible because loads are always
//   PARAMETER-1 and the counters stop in IDLE/DONE.
// STRUCTURE
//  Shared package roulette_pkg:
//   - state encodings SPN_IDLE=2'b00, SPN_SPIN=2'b01, SPN_DONE=2'b10
//   - NUM_W=5 and LFSR tap constants, reused by the game FSM and HEX decoder
//  One sub-module, roulette_lfsr (Clock, reset, SEED param, q[4:0]): free-running
//   register plus feedback. The FSM, counters and edge detect stay in roulette_spinner.
// TESTING (SPIN_CYCLES=8, TICK_DIV=2, SEED=5'b00001 unless stated)
//  1 Reset pulse mid-run -> all outputs 0 and state IDLE immediately (async, before
//    next edge). The LFSR then runs 00001,00010,00100,01001,10010...
//  2 spin 0->1 at edge N -> busy=1 for edges N+1..N+8; rand_valid=1 and busy=0 after
//    edge N+8. randnum equals the LFSR value at that edge and stays stable while spin toggles off.
//  3 Extra spin pulses while busy -> no effect: busy still falls exactly 8 cycles
//    after the first press, and only one result is produced.
//  4 LFSR free-run 62 cycles -> exactly 31 distinct values, never 0, sequence repeats.
//    1000 spins with random press gaps -> every randnum in 1..31.
//  5 Assert reset at cycle 4 of a spin -> busy=0, rand_valid=0, randnum=0. A new spin
//    after release completes normally in 8 cycles.
//  6 SEED=0 -> LFSR starts at 5'b00001. Second spin from DONE -> rand_valid drops one
//    cycle after press and a new result is valid 8 cycles later.

Source files
------------

// File: rtl/roulette_spinner_pkg.sv
// Shared roulette definitions: spinner state encoding, number width and LFSR taps.
// Also used by the game FSM and the HEX decoder.
package roulette_pkg;

    localparam int NUM_W       = 5;
    localparam int LFSR_TAP_HI = 4;
    localparam int LFSR_TAP_LO = 2;

    localparam logic [NUM_W-1:0] LFSR_SAFE_SEED = 5'b00001;

    typedef enum logic [1:0] {
        SPN_IDLE = 2'b00,
        SPN_SPIN = 2'b01,
        SPN_DONE = 2'b10
    } spin_state_e;

    // Fibonacci step for x^5 + x^3 + 1; the all-zero state is never reached from a legal seed.
    function automatic logic [NUM_W-1:0] lfsrNext(input logic [NUM_W-1:0] cur);
        return {cur[NUM_W-2:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
    endfunction

    function automatic logic [NUM_W-1:0] legalSeed(input logic [NUM_W-1:0] seed);
        return (seed == '0) ? LFSR_SAFE_SEED : seed;
    endfunction

endpackage

// File: rtl/roulette_spinner_if.sv
// Spin request and result bundle between the roulette spinner and its consumers.
interface roulette_spinner_if;
    import roulette_pkg::*;

    logic             spin;
    logic [NUM_W-1:0] randnum;
    logic             rand_valid;
    logic             busy;
    logic [NUM_W-1:0] spin_display;

    modport master (
        output spin,
        input  randnum,
        input  rand_valid,
        input  busy,
        input  spin_display
    );

    modport slave (
        input  spin,
        output randnum,
        output rand_valid,
        output busy,
        output spin_display
    );

endinterface

// File: rtl/roulette_spinner_lfsr.sv
// Free-running 5-bit maximal-length LFSR; advances every cycle regardless of spinner state.
module roulette_lfsr
    import roulette_pkg::*;
#(
    parameter logic [NUM_W-1:0] SEED = 5'b00001
) (
    input  logic             Clock,
    input  logic             reset,
    output logic [NUM_W-1:0] q
);

    // A zero seed would lock the register at zero forever.
    localparam logic [NUM_W-1:0] SEED_EFF = legalSeed(SEED);

    logic [NUM_W-1:0] q_q;
    logic [NUM_W-1:0] q_d;

    assign q_d = lfsrNext(q_q);

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            q_q <= SEED_EFF;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/roulette_spinner.sv
// Roulette number source: a spin press runs the wheel for SPIN_CYCLES clocks, then
// latches the LFSR value as a stable 1..31 result until the next press.
module roulette_spinner
    import roulette_pkg::*;
#(
    parameter logic [NUM_W-1:0] SEED        = 5'b00001,
    parameter logic [31:0]      SPIN_CYCLES = 32'd50_000_000,
    parameter logic [31:0]      TICK_DIV    = 32'd2_500_000
) (
    input  logic               Clock,
    input  logic               reset,
    roulette_spinner_if.slave  bus
);

    spin_state_e      state_q;
    logic             spin_q;
    logic [31:0]      cnt_q;
    logic [31:0]      tick_q;
    logic [NUM_W-1:0] randnum_q;
    logic             randValid_q;
    logic             busy_q;
    logic [NUM_W-1:0] spinDisplay_q;
    logic [NUM_W-1:0] lfsr_q;
    logic             spinRise;

    roulette_lfsr #(
        .SEED (SEED)
    ) uLfsr (
        .Clock (Clock),
        .reset (reset),
        .q     (lfsr_q)
    );

    assign spinRise = bus.spin & ~spin_q;

    // Presses while spinning are ignored; a press in DONE withdraws the old result on the same edge.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q       <= SPN_IDLE;
            spin_q        <= 1'b0;
            cnt_q         <= '0;
            tick_q        <= '0;
            randnum_q     <= '0;
            randValid_q   <= 1'b0;
            busy_q        <= 1'b0;
            spinDisplay_q <= '0;
        end else begin
            spin_q <= bus.spin;
            case (state_q)
                SPN_IDLE, SPN_DONE: begin
                    if (spinRise) begin
                        state_q     <= SPN_SPIN;
                        cnt_q       <= SPIN_CYCLES - 32'd1;
                        tick_q      <= TICK_DIV - 32'd1;
                        busy_q      <= 1'b1;
                        randValid_q <= 1'b0;
                    end
                end
                SPN_SPIN: begin
                    if (cnt_q == '0) begin
                        state_q       <= SPN_DONE;
                        randnum_q     <= lfsr_q;
                        spinDisplay_q <= lfsr_q;
                        randValid_q   <= 1'b1;
                        busy_q        <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                        if (tick_q == '0) begin
                            spinDisplay_q <= lfsr_q;
                            tick_q        <= TICK_DIV - 32'd1;
                        end else begin
                            tick_q <= tick_q - 32'd1;
                        end
                    end
                end
                default: begin
                    state_q <= SPN_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.randnum      = randnum_q;
    assign bus.rand_valid   = randValid_q;
    assign bus.busy         = busy_q;
    assign bus.spin_display = spinDisplay_q;

endmodule

// File: tb/tb_roulette_spinner.sv
// Bench for roulette_spinner: vector table, hand-written corner sequences and
// random presses checked against a timeline-based reference model.
module tb_roulette_spinner;
    import roulette_pkg::*;

    localparam int SPIN_N = 8;
    localparam int TICK_N = 2;

    logic Clock = 1'b0;
    logic reset = 1'b0;

    roulette_spinner_if busA ();
    roulette_spinner_if busB ();

    roulette_spinner #(
        .SEED        (5'b00001),
        .SPIN_CYCLES (32'd8),
        .TICK_DIV    (32'd2)
    ) dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (busA)
    );

    roulette_spinner #(
        .SEED        (5'b00000),
        .SPIN_CYCLES (32'd8),
        .TICK_DIV    (32'd2)
    ) dut0 (
        .Clock (Clock),
        .reset (reset),
        .bus   (busB)
    );

    always #5 Clock = ~Clock;

    int compared   = 0;
    int mismatched = 0;

    logic [4:0] seq [31];

    int         edgeIdx;
    int         startEdge;
    logic       spinLevel;
    logic       prevLevel;
    logic       mBusy;
    logic       mValid;
    logic [4:0] mRand;
    logic [4:0] mDisp;

    typedef struct {
        logic       spin;
        logic       expBusy;
        logic       expValid;
        logic [4:0] expRand;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        edgeIdx   = 0;
        startEdge = 0;
        prevLevel = 1'b0;
        mBusy     = 1'b0;
        mValid    = 1'b0;
        mRand     = '0;
        mDisp     = '0;
    endtask

    // The model works from the press edge number: the result appears SPIN_N edges later and
    // the display refreshes on every TICK_N-th edge in between.
    task automatic modelEdge();
        logic [4:0] now;
        logic       rise;
        int         k;
        now       = seq[edgeIdx % 31];
        rise      = spinLevel & ~prevLevel;
        prevLevel = spinLevel;
        if (mBusy) begin
            k = edgeIdx - startEdge;
            if (k == SPIN_N) begin
                mBusy  = 1'b0;
                mValid = 1'b1;
                mRand  = now;
                mDisp  = now;
            end else if (k % TICK_N == 0) begin
                mDisp = now;
            end
        end else if (rise) begin
            mBusy     = 1'b1;
            mValid    = 1'b0;
            startEdge = edgeIdx;
        end
        edgeIdx++;
    endtask

    task automatic checkOutput();
        check("busy",       int'(busA.busy),         int'(mBusy));
        check("randValid",  int'(busA.rand_valid),   int'(mValid));
        check("randnum",    int'(busA.randnum),      int'(mRand));
        check("display",    int'(busA.spin_display), int'(mDisp));
        check("busy0",      int'(busB.busy),         int'(mBusy));
        check("randValid0", int'(busB.rand_valid),   int'(mValid));
        check("randnum0",   int'(busB.randnum),      int'(mRand));
        check("display0",   int'(busB.spin_display), int'(mDisp));
        if (mValid) begin
            check("randRange", int'(busA.randnum >= 5'd1 && busA.randnum <= 5'd31), 1);
        end
    endtask

    task automatic applyStimulus(input logic s);
        spinLevel = s;
        busA.spin = s;
        busB.spin = s;
        @(posedge Clock);
        modelEdge();
        @(negedge Clock);
        checkOutput();
    endtask

    // Called at a falling edge; reset is raised between edges so its effect must be immediate.
    task automatic applyReset();
        #2 reset = 1'b1;
        #1;
        check("rstBusy",   int'(busA.busy),         0);
        check("rstValid",  int'(busA.rand_valid),   0);
        check("rstRand",   int'(busA.randnum),      0);
        check("rstDisp",   int'(busA.spin_display), 0);
        check("rstState",  int'(dut.state_q),       int'(SPN_IDLE));
        check("rstLfsr",   int'(dut.lfsr_q),        1);
        check("rstLfsr0",  int'(dut0.lfsr_q),       1);
        check("rstBusy0",  int'(busB.busy),         0);
        @(negedge Clock);
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [4:0] expFirst [5];
        logic [4:0] vals [62];
        int         distinct;
        int         guard;
        int         gap;
        int         hold;

        seq[0] = 5'b00001;
        for (int i = 1; i < 31; i++) begin
            seq[i] = {seq[i-1][3:0], seq[i-1][4] ^ seq[i-1][2]};
        end
        expFirst[0] = 5'b00001;
        expFirst[1] = 5'b00010;
        expFirst[2] = 5'b00100;
        expFirst[3] = 5'b01001;
        expFirst[4] = 5'b10010;

        for (int i = 0; i < 21; i++) begin
            vecs[i] = '{spin: 1'b0, expBusy: 1'b0, expValid: 1'b0, expRand: 5'd0};
        end
        vecs[1].spin = 1'b1;
        vecs[2].spin = 1'b1;
        vecs[4].spin = 1'b1;
        vecs[11].spin = 1'b1;
        for (int i = 1; i <= 8; i++) vecs[i].expBusy = 1'b1;
        for (int i = 11; i <= 18; i++) vecs[i].expBusy = 1'b1;
        for (int i = 9; i <= 10; i++) vecs[i].expValid = 1'b1;
        for (int i = 19; i <= 20; i++) vecs[i].expValid = 1'b1;
        for (int i = 9; i <= 18; i++) vecs[i].expRand = 5'd25;
        for (int i = 19; i <= 20; i++) vecs[i].expRand = 5'd6;

        spinLevel = 1'b0;
        busA.spin = 1'b0;
        busB.spin = 1'b0;
        modelReset();
        @(negedge Clock);
        applyReset();

        $display("[TB] vector table: press, ignored re-press, respin from DONE");
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].spin);
            check($sformatf("tblBusy[%0d]", i),  int'(busA.busy),       int'(vecs[i].expBusy));
            check($sformatf("tblValid[%0d]", i), int'(busA.rand_valid), int'(vecs[i].expValid));
            check($sformatf("tblRand[%0d]", i),  int'(busA.randnum),    int'(vecs[i].expRand));
        end

        $display("[TB] LFSR free run");
        applyReset();
        for (int i = 0; i < 62; i++) begin
            vals[i] = dut.lfsr_q;
            if (i < 5) check("lfsrStart", int'(vals[i]), int'(expFirst[i]));
            check("lfsrNonZero", int'(vals[i] != 5'd0), 1);
            check("lfsrSeq", int'(vals[i]), int'(seq[i % 31]));
            check("lfsrSeed0", int'(dut0.lfsr_q), int'(seq[i % 31]));
            if (i >= 31) check("lfsrRepeat", int'(vals[i]), int'(vals[i-31]));
            applyStimulus(1'b0);
        end
        distinct = 0;
        for (int i = 0; i < 31; i++) begin
            int seen;
            seen = 0;
            for (int j = 0; j < i; j++) if (vals[j] == vals[i]) seen = 1;
            if (seen == 0) distinct++;
        end
        check("lfsrDistinct", distinct, 31);

        $display("[TB] spin held high gives a single spin");
        for (int i = 0; i < 20; i++) applyStimulus(1'b1);
        check("heldDone", int'(busA.rand_valid), 1);
        applyStimulus(1'b0);

        $display("[TB] reset during a spin, then a clean spin");
        applyStimulus(1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0);
        check("midSpinBusy", int'(busA.busy), 1);
        applyReset();
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        for (int i = 0; i < SPIN_N - 1; i++) applyStimulus(1'b0);
        check("postRstBusy", int'(busA.busy), 1);
        applyStimulus(1'b0);
        check("postRstDone", int'(busA.rand_valid), 1);
        check("postRstDisp", int'(busA.spin_display), int'(busA.randnum));

        $display("[TB] second spin from DONE");
        applyStimulus(1'b1);
        check("respinWithdraw", int'(busA.rand_valid), 0);
        for (int i = 0; i < SPIN_N; i++) applyStimulus(1'b0);
        check("respinValid", int'(busA.rand_valid), 1);

        $display("[TB] spin high while reset releases");
        busA.spin = 1'b1;
        busB.spin = 1'b1;
        spinLevel = 1'b1;
        applyReset();
        applyStimulus(1'b1);
        check("rstHighRise", int'(busA.busy), 1);
        for (int i = 0; i < SPIN_N; i++) applyStimulus(1'b0);

        $display("[TB] 1000 random spins");
        for (int n = 0; n < 1000; n++) begin
            gap  = $urandom_range(4, 0);
            hold = $urandom_range(3, 1);
            for (int i = 0; i <= gap; i++) applyStimulus(1'b0);
            for (int i = 0; i < hold; i++) applyStimulus(1'b1);
            guard = 0;
            while (mBusy && guard < 50) begin
                applyStimulus(1'($urandom_range(1, 0)));
                guard++;
            end
            check("spinBounded", int'(guard < 50), 1);
            check("spinResult", int'(busA.rand_valid), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
